// File: rtl/wishbone_master_pkg.sv
// Shared definitions for the FIFO-to-Wishbone bridge master: bus widths and
// the controller state encoding.
package wishbone_master_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_BUS  = 3'd1,
    WR_ADDR = 3'd2,
    WR_DATA = 3'd3,
    WR_BUS  = 3'd4,
    DONE    = 3'd5
  } state_e;

endpackage

// File: rtl/wishbone_master.sv
// Single-transfer Wishbone master fed from a FIFO: the first word is the
// address, a write takes a second word as data. All outputs are registered.
//
//   state   | meaning
//   IDLE    | waiting for a read/write request with a non-empty FIFO
//   RD_BUS  | read cycle on the bus, waiting for ack
//   WR_ADDR | address latched, bus idle for one cycle
//   WR_DATA | latching write data from the FIFO
//   WR_BUS  | write cycle on the bus, waiting for ack
//   DONE    | transfer finished, waiting for both request levels to drop
module wishbone_master
  import wishbone_master_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [DATA_W-1:0] wb_dat_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_ack_i,
  input  logic              fifo_read_en,
  input  logic              fifo_write_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data_in,
  output logic [DATA_W-1:0] fifo_data_out
);

  state_e            state_q, state_d;
  logic              cyc_q, cyc_d;
  logic              stb_q, stb_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rdata_q <= rdata_d;
    end
  end

  // Bus strobes are set on the edge that enters a bus state so they are
  // already valid during the first bus cycle.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          if (fifo_read_en) begin
            adr_d   = ADDR_W'(fifo_data_in);
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            we_d    = 1'b0;
            state_d = RD_BUS;
          end else if (fifo_write_en) begin
            adr_d   = ADDR_W'(fifo_data_in);
            state_d = WR_ADDR;
          end
        end
      end
      RD_BUS: begin
        if (wb_ack_i) begin
          rdata_d = wb_dat_i;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          state_d = DONE;
        end
      end
      WR_ADDR: state_d = WR_DATA;
      WR_DATA: begin
        dat_d   = fifo_data_in;
        cyc_d   = 1'b1;
        stb_d   = 1'b1;
        we_d    = 1'b1;
        state_d = WR_BUS;
      end
      WR_BUS: begin
        if (wb_ack_i) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!fifo_read_en && !fifo_write_en) state_d = IDLE;
      end
      default: begin
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        we_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign wb_cyc_o      = cyc_q;
  assign wb_stb_o      = stb_q;
  assign wb_we_o       = we_q;
  assign wb_adr_o      = adr_q;
  assign wb_dat_o      = dat_q;
  assign fifo_data_out = rdata_q;

endmodule

// File: tb/tb_wishbone_master.sv
// Directed bench for wishbone_master: expected transfers are queued when a
// request is driven and compared when the bus cycle appears.
module tb_wishbone_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic        wb_ack_i;
  logic        fifo_read_en, fifo_write_en, fifo_empty;
  logic [31:0] fifo_data_in, fifo_data_out;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } txn_t;

  txn_t sb[$];
  txn_t exp_t;
  int   errors = 0;
  int   checks = 0;
  int   n;
  int   cyc_cnt;

  always #5 clk = ~clk;

  wishbone_master dut (
    .clk          (clk),
    .rst          (rst),
    .wb_cyc_o     (wb_cyc_o),
    .wb_stb_o     (wb_stb_o),
    .wb_we_o      (wb_we_o),
    .wb_adr_o     (wb_adr_o),
    .wb_dat_o     (wb_dat_o),
    .wb_dat_i     (wb_dat_i),
    .wb_ack_i     (wb_ack_i),
    .fifo_read_en (fifo_read_en),
    .fifo_write_en(fifo_write_en),
    .fifo_empty   (fifo_empty),
    .fifo_data_in (fifo_data_in),
    .fifo_data_out(fifo_data_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input string tag, output int edges);
    edges = 0;
    while (wb_cyc_o !== 1'b1 && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    chk(tag, {31'd0, wb_cyc_o}, 32'd1);
  endtask

  initial begin
    rst = 1'b0;
    wb_dat_i = '0; wb_ack_i = 1'b0;
    fifo_read_en = 1'b0; fifo_write_en = 1'b0; fifo_empty = 1'b1; fifo_data_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {29'd0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_fdo", fifo_data_out, 32'd0);
    rst = 1'b1;

    // read transfer, first request right after reset
    @(negedge clk);
    fifo_read_en = 1'b1; fifo_empty = 1'b0; fifo_data_in = 32'h1a2a3a4a;
    sb.push_back('{1'b0, 32'h1a2a3a4a, 32'hffffffff});
    @(negedge clk);
    chk("rd_cyc_first_edge", {31'd0, wb_cyc_o}, 32'd1);
    exp_t = sb.pop_front();
    chk("rd_adr", wb_adr_o, exp_t.adr);
    chk("rd_stb_we", {30'd0, wb_stb_o, wb_we_o}, {30'd0, 1'b1, exp_t.we});
    fifo_empty = 1'b1; fifo_data_in = 32'h0badf00d;
    @(negedge clk);
    chk("rd_wait_held", {wb_adr_o[30:0], wb_cyc_o}, {exp_t.adr[30:0], 1'b1});
    wb_dat_i = exp_t.dat; wb_ack_i = 1'b1;
    @(negedge clk);
    wb_ack_i = 1'b0; wb_dat_i = 32'h0;
    chk("rd_fdo", fifo_data_out, exp_t.dat);
    chk("rd_end_ctl", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
    fifo_empty = 1'b0;
    cyc_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (wb_cyc_o) cyc_cnt++;
    end
    chk("rd_level_single", cyc_cnt, 0);
    fifo_read_en = 1'b0;
    @(negedge clk);

    // write transfer
    fifo_write_en = 1'b1; fifo_data_in = 32'h1b2b3b4b;
    sb.push_back('{1'b1, 32'h1b2b3b4b, 32'heeeeeeee});
    @(negedge clk);
    chk("wr_addr_idle", {31'd0, wb_cyc_o}, 32'd0);
    fifo_data_in = 32'heeeeeeee; fifo_write_en = 1'b0;
    wait_cyc("wr_cyc_seen", n);
    chk("wr_latency", n, 2);
    exp_t = sb.pop_front();
    chk("wr_adr", wb_adr_o, exp_t.adr);
    chk("wr_dat", wb_dat_o, exp_t.dat);
    chk("wr_stb_we", {30'd0, wb_stb_o, wb_we_o}, {30'd0, 1'b1, exp_t.we});
    chk("fdo_held", fifo_data_out, 32'hffffffff);
    wb_ack_i = 1'b1;
    @(negedge clk);
    wb_ack_i = 1'b0;
    chk("wr_end_ctl", {29'd0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd0);
    @(negedge clk);

    // ack already high before the write bus phase
    wb_ack_i = 1'b1; fifo_write_en = 1'b1; fifo_data_in = 32'h00000100;
    sb.push_back('{1'b1, 32'h00000100, 32'h0000cafe});
    @(negedge clk);
    fifo_data_in = 32'h0000cafe; fifo_write_en = 1'b0;
    cyc_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (wb_cyc_o) begin
        cyc_cnt++;
        exp_t = sb.pop_front();
        chk("preack_adr", wb_adr_o, exp_t.adr);
        chk("preack_dat", wb_dat_o, exp_t.dat);
      end
    end
    chk("preack_one_cycle", cyc_cnt, 1);
    wb_ack_i = 1'b0;

    // simultaneous read and write request: read wins
    fifo_read_en = 1'b1; fifo_write_en = 1'b1; fifo_data_in = 32'h00000055;
    sb.push_back('{1'b0, 32'h00000055, 32'h12345678});
    @(negedge clk);
    exp_t = sb.pop_front();
    chk("prio_cyc_we", {30'd0, wb_cyc_o, wb_we_o}, {30'd0, 1'b1, exp_t.we});
    chk("prio_adr", wb_adr_o, exp_t.adr);
    wb_dat_i = exp_t.dat; wb_ack_i = 1'b1;
    @(negedge clk);
    wb_ack_i = 1'b0; fifo_read_en = 1'b0; fifo_write_en = 1'b0;
    chk("prio_fdo", fifo_data_out, exp_t.dat);
    @(negedge clk);

    // empty FIFO blocks requests
    fifo_empty = 1'b1; fifo_read_en = 1'b1; fifo_write_en = 1'b1; fifo_data_in = 32'hdeadbeef;
    cyc_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (wb_cyc_o) cyc_cnt++;
    end
    chk("empty_no_cyc", cyc_cnt, 0);
    chk("empty_adr_kept", wb_adr_o, 32'h00000055);
    fifo_read_en = 1'b0; fifo_write_en = 1'b0; fifo_empty = 1'b0;
    @(negedge clk);

    // reset in the middle of a read
    fifo_read_en = 1'b1; fifo_data_in = 32'h00000077;
    @(negedge clk);
    chk("mid_rst_cyc_pre", {31'd0, wb_cyc_o}, 32'd1);
    fifo_read_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_ctl", {29'd0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd0);
    chk("mid_rst_adr", wb_adr_o, 32'd0);
    chk("mid_rst_fdo", fifo_data_out, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {31'd0, wb_cyc_o}, 32'd0);
    fifo_read_en = 1'b1; fifo_data_in = 32'h00000088;
    sb.push_back('{1'b0, 32'h00000088, 32'ha5a5a5a5});
    @(negedge clk);
    exp_t = sb.pop_front();
    chk("post_rst_cyc", {31'd0, wb_cyc_o}, 32'd1);
    chk("post_rst_adr", wb_adr_o, exp_t.adr);
    wb_dat_i = exp_t.dat; wb_ack_i = 1'b1;
    @(negedge clk);
    wb_ack_i = 1'b0; fifo_read_en = 1'b0;
    chk("post_rst_fdo", fifo_data_out, exp_t.dat);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
